// File: rtl/fq_writer.sv
// Record-queue writer: pops fixed-size records from a FIFO and writes them
// beat by beat into a power-of-two ring of entries in memory.
module fq_writer #(
    parameter int BEAT_W    = 32,
    parameter int REC_BEATS = 4,
    parameter int Q_LOG2    = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fifo_empty_i,
    input  logic [REC_BEATS*BEAT_W-1:0]   fifo_data_i,
    output logic                          fifo_pop_o,
    input  logic                          en_i,
    input  logic [ADDR_W-1:0]             base_i,
    input  logic [Q_LOG2-1:0]             head_i,
    output logic [Q_LOG2-1:0]             tail_o,
    output logic                          wr_valid_o,
    input  logic                          wr_ready_i,
    output logic [ADDR_W-1:0]             wr_addr_o,
    output logic [BEAT_W-1:0]             wr_data_o,
    output logic                          wr_last_o,
    input  logic                          ovf_clr_i,
    output logic                          overflow_o,
    output logic                          busy_o,
    output logic                          irq_o
);

    localparam int BW = $clog2(REC_BEATS);
    localparam logic [BW-1:0] LAST = BW'(REC_BEATS - 1);
    localparam logic [ADDR_W-1:0] BYTES = ADDR_W'(BEAT_W / 8);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]                    state_q, state_d;
    logic [BW-1:0]                 beat_q, beat_d;
    logic [Q_LOG2-1:0]             tail_q, tail_d;
    logic [REC_BEATS*BEAT_W-1:0]   rec_q, rec_d;
    logic                          ovf_q, ovf_d;
    logic                          irq_q, irq_d;

    logic                          pop;
    logic                          full;
    logic                          hs;
    logic                          last_beat;
    logic [Q_LOG2-1:0]             tail_inc;
    logic [ADDR_W-1:0]             idx;

    always_comb begin
        tail_inc  = tail_q + Q_LOG2'(1);
        full      = (tail_inc == head_i);
        last_beat = (beat_q == LAST);
        pop       = !reset && (state_q == IDLE) && en_i && !fifo_empty_i;
        hs        = !reset && (state_q == SEND) && wr_ready_i;

        state_d = state_q;
        beat_d  = beat_q;
        tail_d  = tail_q;
        rec_d   = rec_q;
        ovf_d   = ovf_q;
        irq_d   = 1'b0;

        // clear first so a coincident drop re-sets the flag
        if (ovf_clr_i) ovf_d = 1'b0;

        if (pop) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                rec_d   = fifo_data_i;
                beat_d  = '0;
                state_d = SEND;
            end
        end

        if (hs) begin
            if (last_beat) begin
                tail_d  = tail_inc;
                irq_d   = 1'b1;
                beat_d  = '0;
                state_d = IDLE;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            tail_q  <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tail_q  <= tail_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        rec_q <= rec_d;
    end

    assign idx        = ADDR_W'({tail_q, beat_q});
    assign wr_addr_o  = base_i + idx * BYTES;
    assign wr_data_o  = rec_q[int'(beat_q)*BEAT_W +: BEAT_W];
    assign wr_valid_o = !reset && (state_q == SEND);
    assign wr_last_o  = wr_valid_o && last_beat;
    assign busy_o     = wr_valid_o;
    assign irq_o      = irq_q && !reset;
    assign fifo_pop_o = pop;
    assign tail_o     = tail_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_fq_writer.sv
// Directed bench for fq_writer: single record, backpressure, overflow,
// en drop, ring wrap and mid-record reset.
module tb_fq_writer;

    logic         clk;
    logic         reset;
    logic         fifo_empty;
    logic [127:0] fifo_data;
    logic         pop;
    logic         en;
    logic [31:0]  base;
    logic [3:0]   head;
    logic [3:0]   tail;
    logic         wr_valid;
    logic         wr_ready;
    logic [31:0]  wr_addr;
    logic [31:0]  wr_data;
    logic         wr_last;
    logic         ovf_clr;
    logic         overflow;
    logic         busy;
    logic         irq;

    int pass_n;
    int total_n;
    logic [3:0] exp_tail;

    fq_writer dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_pop_o   (pop),
        .en_i         (en),
        .base_i       (base),
        .head_i       (head),
        .tail_o       (tail),
        .wr_valid_o   (wr_valid),
        .wr_ready_i   (wr_ready),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .wr_last_o    (wr_last),
        .ovf_clr_i    (ovf_clr),
        .overflow_o   (overflow),
        .busy_o       (busy),
        .irq_o        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one record through the writer; optional 3-cycle stall and en drop
    task automatic send_rec(input logic [127:0] d, input int stall_beat,
                            input int en_drop_beat);
        logic [31:0] a;
        fifo_data  = d;
        fifo_empty = 1'b0;
        en         = 1'b1;
        wr_ready   = 1'b1;
        #1;
        chk("pop", pop, 1);
        chk("idle_valid", wr_valid, 0);
        tick();
        fifo_data = ~d;
        for (int b = 0; b < 4; b++) begin
            if (b == en_drop_beat) en = 1'b0;
            if (b == 3) fifo_empty = (en_drop_beat >= 0) ? 1'b0 : 1'b1;
            a = base + 32'((int'(exp_tail) * 4 + b) * 4);
            if (b == stall_beat) begin
                for (int s = 0; s < 3; s++) begin
                    wr_ready = 1'b0;
                    #1;
                    chk("stall_valid", wr_valid, 1);
                    chk("stall_addr", wr_addr, a);
                    chk("stall_data", wr_data, d[b*32 +: 32]);
                    chk("stall_last", wr_last, 0);
                    tick();
                end
            end
            wr_ready = 1'b1;
            #1;
            chk("valid", wr_valid, 1);
            chk("addr", wr_addr, a);
            chk("data", wr_data, d[b*32 +: 32]);
            chk("last", wr_last, (b == 3) ? 1 : 0);
            chk("send_pop", pop, 0);
            chk("busy", busy, 1);
            tick();
        end
        exp_tail = exp_tail + 4'd1;
        chk("done_valid", wr_valid, 0);
        chk("tail", tail, exp_tail);
        chk("irq", irq, 1);
        chk("done_busy", busy, 0);
        chk("done_pop", pop, 0);
        tick();
        chk("irq_pulse", irq, 0);
        if (en_drop_beat >= 0) begin
            for (int c = 0; c < 3; c++) begin
                chk("en_off_pop", pop, 0);
                chk("en_off_busy", busy, 0);
                tick();
            end
        end
        fifo_empty = 1'b1;
    endtask

    initial begin
        pass_n     = 0;
        total_n    = 0;
        exp_tail   = 4'd0;
        reset      = 1'b1;
        en         = 1'b1;
        fifo_empty = 1'b0;
        fifo_data  = '0;
        base       = 32'h1000;
        head       = 4'd1;
        wr_ready   = 1'b1;
        ovf_clr    = 1'b0;

        tick();
        tick();
        chk("rst_pop", pop, 0);
        chk("rst_valid", wr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tail", tail, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_irq", irq, 0);

        // full queue: head=1, tail=0
        reset = 1'b0;
        #1;
        chk("full_pop", pop, 1);
        tick();
        chk("full_ovf", overflow, 1);
        chk("full_valid", wr_valid, 0);
        chk("full_busy", busy, 0);
        chk("full_tail", tail, 0);
        ovf_clr = 1'b1;
        #1;
        chk("full_pop2", pop, 1);
        tick();
        chk("ovf_set_wins", overflow, 1);
        en = 1'b0;
        #1;
        chk("en_off_pop0", pop, 0);
        tick();
        chk("ovf_clr", overflow, 0);
        ovf_clr    = 1'b0;
        fifo_empty = 1'b1;
        head       = 4'd0;
        en         = 1'b1;
        #1;
        chk("empty_pop", pop, 0);
        tick();

        send_rec(128'h44444444_33333333_22222222_11111111, -1, -1);
        send_rec(128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 2, -1);
        send_rec(128'h0F0E0D0C_0B0A0908_07060504_03020100, -1, 1);
        chk("en_drop_tail", tail, 3);

        head = 4'd3;
        for (int r = 0; r < 12; r++)
            send_rec({4{32'(r * 32'h01010101)}}, -1, -1);
        chk("pre_wrap_tail", tail, 15);
        send_rec(128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, -1, -1);
        chk("wrap_tail", tail, 0);
        send_rec(128'h12345678_9ABCDEF0_0BADF00D_DEADBEEF, -1, -1);
        chk("post_wrap_tail", tail, 1);

        // reset while beat 2 is on the bus
        fifo_data  = 128'h55555555_66666666_77777777_88888888;
        fifo_empty = 1'b0;
        en         = 1'b1;
        #1;
        chk("rr_pop", pop, 1);
        tick();
        tick();
        tick();
        chk("rr_beat2_valid", wr_valid, 1);
        chk("rr_beat2_addr", wr_addr, 32'h1000 + 32'd16 + 32'd8);
        reset = 1'b1;
        #1;
        chk("rr_valid", wr_valid, 0);
        chk("rr_last", wr_last, 0);
        chk("rr_busy", busy, 0);
        chk("rr_pop0", pop, 0);
        tick();
        chk("rr_tail", tail, 0);
        chk("rr_busy2", busy, 0);
        chk("rr_pop1", pop, 0);
        chk("rr_irq", irq, 0);
        tick();
        chk("rr_pop2", pop, 0);
        reset = 1'b0;
        #1;
        chk("rr_release_pop", pop, 1);
        chk("rr_release_valid", wr_valid, 0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule

// File: doc/fq_writer.md
FQ_WRITER -- requirements
Module: fq_writer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter BEAT_W, default 32, SHALL set the memory write data width in bits (multiple of 8).
REQ-003 Parameter REC_BEATS, default 4, SHALL set the beats per record (power of two, >= 2).
REQ-004 Parameter Q_LOG2, default 4, SHALL set the log2 of the in-memory queue entry count.
REQ-005 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port reset, input, 1: synchronous active-high reset.
REQ-008 Port fifo_empty_i, input, 1: upstream record FIFO empty.
REQ-009 Port fifo_data_i, input, REC_BEATS*BEAT_W: FIFO head record, fall-through valid when not empty; beat 0 is the LSBs.
REQ-010 Port fifo_pop_o, output, 1: pops the FIFO head this cycle.
REQ-011 Port en_i, input, 1: queue enable.
REQ-012 Port base_i, input, ADDR_W: queue base byte address, aligned to REC_BEATS*BEAT_W/8.
REQ-013 Port head_i, input, Q_LOG2: software consumer index.
REQ-014 Port tail_o, output, Q_LOG2: producer index.
REQ-015 Ports wr_valid_o (out, 1), wr_ready_i (in, 1), wr_addr_o (out, ADDR_W), wr_data_o (out, BEAT_W), wr_last_o (out, 1): memory write beat channel.
REQ-016 Port ovf_clr_i, input, 1: clears overflow_o.
REQ-017 Ports overflow_o (out, 1, sticky), busy_o (out, 1, FSM not IDLE), irq_o (out, 1, one-cycle record-done pulse).

Function
REQ-018 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-019 In IDLE with en_i=1, fifo_empty_i=0, and queue not full ((tail_o+1) mod 2^Q_LOG2 != head_i), the block SHALL assert fifo_pop_o, latch fifo_data_i, set beat=0, and enter SEND next cycle.
REQ-020 In IDLE with en_i=1, fifo_empty_i=0, and queue full, the block SHALL assert fifo_pop_o for one cycle, discard the record, set overflow_o next cycle, and remain in IDLE.
REQ-021 fifo_pop_o SHALL never be asserted while fifo_empty_i=1, while in SEND, or while en_i=0.
REQ-022 In SEND, wr_valid_o SHALL be 1 and wr_data_o SHALL equal latched beat[beat].
REQ-023 wr_addr_o SHALL equal base_i + (tail_o*REC_BEATS + beat)*(BEAT_W/8), computed modulo 2^ADDR_W.
REQ-024 wr_last_o SHALL equal wr_valid_o && beat==REC_BEATS-1.
REQ-025 While wr_valid_o=1 and wr_ready_i=0, wr_addr_o, wr_data_o, and wr_last_o SHALL hold stable, and wr_valid_o SHALL NOT deassert.
REQ-026 On a handshake with beat<REC_BEATS-1, beat SHALL increment.
REQ-027 On the last-beat handshake, tail_o SHALL increment with wrap to 0 after 2^Q_LOG2-1, irq_o SHALL pulse in the next cycle, and the FSM SHALL return to IDLE.
REQ-028 Pop-to-first-beat latency SHALL be 1 cycle; back-to-back records SHALL have a 1-cycle IDLE gap (min REC_BEATS+1 cycles/record).
REQ-029 Deasserting en_i during SEND SHALL NOT abort the current record; no new pop occurs until en_i=1.
REQ-030 overflow_o SHALL be sticky until ovf_clr_i=1; if set and clear coincide, set SHALL win.
REQ-031 Fullness SHALL be evaluated using head_i sampled in the IDLE pop cycle only.

Reset
REQ-032 In every cycle reset=1 (taking priority over all inputs, including mid-record), the block SHALL drive fifo_pop_o=0, wr_valid_o=0, wr_last_o=0, irq_o=0, and busy_o=0, then at the next clock edge set state=IDLE, beat=0, tail_o=0, and overflow_o=0.
REQ-033 A partially sent record SHALL be dropped on reset, and the FIFO entry SHALL NOT be re-popped.
REQ-034 wr_addr_o and wr_data_o SHALL be don't-care while wr_valid_o=0.

Verification
REQ-035 Single record with base=0x1000, tail=0, wr_ready_i=1, defaults: pop at cycle N, beats at N+1..N+4 with addr 0x1000/04/08/0C and last on the 4th, tail_o=1, irq_o at N+5.
REQ-036 Backpressure with wr_ready_i low for 3 cycles on beat 2: addr, data, and valid stay stable; the record completes; no beat is duplicated or lost.
REQ-037 Full queue with head_i=1 and tail_o=0 and a record present: one pop, no wr_valid_o, overflow_o=1; ovf_clr_i plus a simultaneous second drop keeps overflow_o=1.
REQ-038 Wrap with tail_o=15 and head_i=3: the record writes at base+15*16, and tail_o becomes 0.
REQ-039 en_i dropped during beat 1: the record finishes, and no further pop occurs while FIFO is non-empty.
REQ-040 reset asserted on beat 2: wr_valid_o=0 in that cycle, then tail_o=0, busy_o=0, and no pop until reset is released.
